// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants, read-source select and address decode helpers for the CPU byte-port responder.
// Pure declarations; no timing or backpressure of its own.
package mem_io_responder_pkg;

    localparam int          BYTE_W       = 8;
    localparam logic [1:0]  IO_SELECT    = 2'b11;
    localparam logic [2:0]  IO_UART_ADDR = 3'h0;
    localparam logic [2:0]  IO_CLK_ADDR  = 3'h4;

    typedef enum logic {
        SRC_IO  = 1'b0,
        SRC_RAM = 1'b1
    } rd_src_e;

    typedef struct packed {
        logic       is_io;   // a[17:16] selects the IO window
        logic       io_hit;  // inside the 8-byte register block at the window base
        logic [2:0] io_off;
    } dec_t;

    function automatic dec_t decode(input logic [17:0] a);
        dec_t d;
        d.is_io  = (a[17:16] == IO_SELECT);
        d.io_hit = (a[15:3] == 13'd0);
        d.io_off = a[2:0];
        return d;
    endfunction

    function automatic logic [BYTE_W-1:0] snap_byte(input logic [31:0] s, input logic [1:0] sel);
        logic [BYTE_W-1:0] b;
        case (sel)
            2'd0:    b = s[7:0];
            2'd1:    b = s[15:8];
            2'd2:    b = s[23:16];
            default: b = s[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_io_responder_sync_byte_fifo.sv
// Single-clock byte FIFO, head visible combinationally; push/pop take effect on the same edge.
// Backpressure: push when full and pop when empty are silently ignored; caller watches full/empty.
module sync_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-port responder: RAM, UART TX/RX FIFOs, cycle counter with coherent snapshot, stop flag.
// Reads return one edge after the address cycle; writes land on the address edge; en_in low freezes the bus.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int RX_DEPTH_LOG2  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    input  logic [31:0] cpu_mem_a,
    input  logic [7:0]  cpu_mem_dout,
    input  logic        cpu_mem_wr,
    output logic [7:0]  cpu_mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int                       RAM_DEPTH    = 1 << RAM_ADDR_WIDTH;
    localparam logic [TX_DEPTH_LOG2:0]   TX_NEAR_FULL = (TX_DEPTH_LOG2 + 1)'((1 << TX_DEPTH_LOG2) - 2);

    logic [7:0]                r_ram [RAM_DEPTH];
    logic [7:0]                r_ram_q;
    rd_src_e                   r_src;
    logic [7:0]                r_io_dat;
    logic [31:0]               r_cnt;
    logic [31:0]               r_snap;
    logic                      r_stop;
    logic                      r_ovf;

    dec_t                      w_dec;
    logic [RAM_ADDR_WIDTH-1:0] w_idx;
    logic                      w_rd;
    logic                      w_wr;
    logic                      w_uart_hit;
    logic                      w_clk_hit;
    logic                      w_snap_hit;
    logic                      w_tx_req;
    logic [7:0]                w_tx_push_dat;
    logic                      w_rx_pop;
    logic [7:0]                w_io_rdata;
    logic                      w_tx_empty;
    logic                      w_tx_full;
    logic [TX_DEPTH_LOG2:0]    w_tx_count;
    logic [7:0]                w_rx_head;
    logic                      w_rx_empty;
    logic                      w_rx_full;
    logic [RX_DEPTH_LOG2:0]    w_rx_count;
    logic                      w_unused;

    assign w_dec      = decode(cpu_mem_a[17:0]);
    assign w_idx      = cpu_mem_a[RAM_ADDR_WIDTH-1:0];
    assign w_rd       = en_in & ~cpu_mem_wr;
    assign w_wr       = en_in & cpu_mem_wr;
    assign w_uart_hit = w_dec.is_io & w_dec.io_hit & (w_dec.io_off == IO_UART_ADDR);
    assign w_clk_hit  = w_dec.is_io & w_dec.io_hit & (w_dec.io_off == IO_CLK_ADDR);
    assign w_snap_hit = w_dec.is_io & w_dec.io_hit & w_dec.io_off[2] & (w_dec.io_off[1:0] != 2'd0);
    assign w_unused   = ^{cpu_mem_a[31:18], w_rx_count};

    // A stop write also emits a 0x00 marker byte so the host side sees end of output.
    assign w_tx_req      = w_wr & ((w_uart_hit & (cpu_mem_dout != 8'h00)) | w_clk_hit);
    assign w_tx_push_dat = w_clk_hit ? 8'h00 : cpu_mem_dout;
    assign w_rx_pop      = w_rd & w_uart_hit;

    always_comb begin
        w_io_rdata = 8'h00;
        if (w_uart_hit) begin
            w_io_rdata = w_rx_empty ? 8'h00 : w_rx_head;
        end else if (w_clk_hit) begin
            w_io_rdata = r_cnt[7:0];
        end else if (w_snap_hit) begin
            w_io_rdata = snap_byte(r_snap, w_dec.io_off[1:0]);
        end
    end

    // RAM is kept out of reset so it maps onto block memory; r_src masks its stale output after reset.
    always_ff @(posedge clk_in) begin
        if (w_wr & ~w_dec.is_io) begin
            r_ram[w_idx] <= cpu_mem_dout;
        end
        if (w_rd & ~w_dec.is_io) begin
            r_ram_q <= r_ram[w_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_src    <= SRC_IO;
            r_io_dat <= 8'h00;
            r_cnt    <= 32'd0;
            r_snap   <= 32'd0;
            r_stop   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (en_in) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_rd) begin
                r_src    <= w_dec.is_io ? SRC_IO : SRC_RAM;
                r_io_dat <= w_io_rdata;
                if (w_clk_hit) begin
                    r_snap <= r_cnt;
                end
            end
            if (w_wr & w_clk_hit) begin
                r_stop <= 1'b1;
            end
            if (w_tx_req & w_tx_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign cpu_mem_din    = (r_src == SRC_RAM) ? r_ram_q : r_io_dat;
    assign io_buffer_full = (w_tx_count >= TX_NEAR_FULL);
    assign tx_valid       = ~w_tx_empty;
    assign rx_ready       = ~w_rx_full;
    assign program_stop   = r_stop;
    assign tx_overflow    = r_ovf;

    sync_byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (w_tx_req),
        .push_data (w_tx_push_dat),
        .pop       (tx_ready),
        .head      (tx_data),
        .empty     (w_tx_empty),
        .full      (w_tx_full),
        .count     (w_tx_count)
    );

    sync_byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (w_rx_pop),
        .head      (w_rx_head),
        .empty     (w_rx_empty),
        .full      (w_rx_full),
        .count     (w_rx_count)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: table-driven RAM vectors plus scripted IO sequences.
module tb_mem_io_responder;

    localparam logic [31:0] IDLE_A = 32'h0003_FFF0;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        en_in;
    logic [31:0] cpu_mem_a;
    logic [7:0]  cpu_mem_dout;
    logic        cpu_mem_wr;
    logic [7:0]  cpu_mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .en_in          (en_in),
        .cpu_mem_a      (cpu_mem_a),
        .cpu_mem_dout   (cpu_mem_dout),
        .cpu_mem_wr     (cpu_mem_wr),
        .cpu_mem_din    (cpu_mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t        vecs[11];
    logic [7:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    int          n_pass = 0;
    int          n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        if (rst_in) m_cnt = 32'd0;
        else if (en_in) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    task automatic idle();
        cpu_mem_wr   = 1'b0;
        cpu_mem_a    = IDLE_A;
        cpu_mem_dout = 8'h00;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        cpu_mem_a    = a;
        cpu_mem_dout = d;
        cpu_mem_wr   = 1'b1;
        tick();
        idle();
    endtask

    task automatic bus_rd(input string nm, input logic [31:0] a, input logic [7:0] exp);
        cpu_mem_a  = a;
        cpu_mem_wr = 1'b0;
        rd_q.push_back(exp);
        tick();
        chk(nm, cpu_mem_din, rd_q.pop_front());
        idle();
    endtask

    task automatic tx_drain(input string nm);
        tx_ready = 1'b1;
        for (int c = 0; c < 64 && tx_q.size() > 0; c++) begin
            if (tx_valid) chk(nm, tx_data, tx_q.pop_front());
            tick();
        end
        chk({nm, "_left"}, tx_q.size(), 0);
        chk({nm, "_valid_after"}, tx_valid, 1'b0);
        tx_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 32'h0002_0010, 8'h3C, 8'h00};
        vecs[3]  = '{1'b0, 32'h0000_0010, 8'h00, 8'h3C};
        vecs[4]  = '{1'b1, 32'h0001_FFFF, 8'h77, 8'h00};
        vecs[5]  = '{1'b1, 32'h0001_0000, 8'h5A, 8'h00};
        vecs[6]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h77};
        vecs[7]  = '{1'b0, 32'h0001_0000, 8'h00, 8'h5A};
        vecs[8]  = '{1'b1, 32'h0003_0008, 8'h99, 8'h00};
        vecs[9]  = '{1'b0, 32'h0003_0008, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 32'hFFFC_0010, 8'h00, 8'h3C};

        m_cnt    = 32'd0;
        rst_in   = 1'b1;
        en_in    = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle();
        tick();
        tick();

        chk("rst_din", cpu_mem_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_buf_full", io_buffer_full, 1'b0);
        chk("rst_stop", program_stop, 1'b0);
        chk("rst_ovf", tx_overflow, 1'b0);

        // 110 edges, en_in low for 10 of them -> counter at 100
        rst_in = 1'b0;
        for (int i = 0; i < 110; i++) begin
            en_in = !(i >= 40 && i < 50);
            tick();
        end
        en_in = 1'b1;
        chk("cnt_model", m_cnt, 32'd100);
        bus_rd("cnt_b0", 32'h0003_0004, 8'd100);
        bus_rd("cnt_b1", 32'h0003_0005, 8'h00);
        bus_rd("cnt_b2", 32'h0003_0006, 8'h00);
        bus_rd("cnt_b3", 32'h0003_0007, 8'h00);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                bus_wr(vecs[i].a, vecs[i].d);
            end else begin
                bus_rd($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
            end
        end

        // Exactly one edge of read latency, and hold while en_in is low
        bus_rd("lat_prime", 32'h0003_0001, 8'h00);
        cpu_mem_a = 32'h0000_0010;
        chk("lat_before_edge", cpu_mem_din, 8'h00);
        tick();
        chk("lat_after_edge", cpu_mem_din, 8'h3C);
        en_in     = 1'b0;
        cpu_mem_a = 32'h0001_FFFF;
        tick();
        chk("en_low_hold", cpu_mem_din, 8'h3C);
        en_in = 1'b1;
        tick();
        chk("en_high_read", cpu_mem_din, 8'h77);
        idle();

        // UART TX: zero byte is not queued
        bus_wr(32'h0003_0000, 8'h48);
        bus_wr(32'h0003_0000, 8'h69);
        bus_wr(32'h0003_0000, 8'h00);
        tx_q.push_back(8'h48);
        tx_q.push_back(8'h69);
        chk("tx_valid_hi", tx_valid, 1'b1);
        chk("tx_head_H", tx_data, 8'h48);
        chk("tx_not_near_full", io_buffer_full, 1'b0);
        tx_drain("tx_hi");

        // Near-full at 14, overflow on the 17th push
        for (int k = 1; k <= 17; k++) begin
            bus_wr(32'h0003_0000, 8'(k));
            if (k <= 16) tx_q.push_back(8'(k));
            if (k == 13) chk("buf_full_13", io_buffer_full, 1'b0);
            if (k == 14) chk("buf_full_14", io_buffer_full, 1'b1);
            if (k == 16) chk("ovf_16", tx_overflow, 1'b0);
            if (k == 17) chk("ovf_17", tx_overflow, 1'b1);
        end
        tx_drain("tx_fill");
        chk("ovf_sticky", tx_overflow, 1'b1);

        // UART RX single byte then empty read
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        bus_rd("rx_41", 32'h0003_0000, 8'h41);
        bus_rd("rx_empty", 32'h0003_0000, 8'h00);
        chk("rx_ready_empty", rx_ready, 1'b1);

        // RX fill to full, then drain in order
        for (int i = 0; i < 16; i++) begin
            rx_data  = 8'(128 + i);
            rx_valid = 1'b1;
            rx_q.push_back(8'(128 + i));
            tick();
        end
        rx_valid = 1'b0;
        chk("rx_ready_full", rx_ready, 1'b0);
        while (rx_q.size() > 0) begin
            bus_rd("rx_order", 32'h0003_0000, rx_q.pop_front());
        end
        bus_rd("rx_drained", 32'h0003_0000, 8'h00);

        // Second snapshot with a non-trivial upper byte; counter keeps moving during the read
        for (int i = 0; i < 300; i++) tick();
        m_snap = m_cnt;
        bus_rd("snap_b0", 32'h0003_0004, m_snap[7:0]);
        bus_rd("snap_b1", 32'h0003_0005, m_snap[15:8]);
        bus_rd("snap_b2", 32'h0003_0006, m_snap[23:16]);
        bus_rd("snap_b3", 32'h0003_0007, m_snap[31:24]);

        // Stop write: sticky flag plus a 0x00 marker queued to TX; bus keeps working
        bus_wr(32'h0003_0004, 8'h55);
        chk("stop_set", program_stop, 1'b1);
        chk("stop_tx_valid", tx_valid, 1'b1);
        chk("stop_tx_zero", tx_data, 8'h00);
        bus_rd("stop_ram_rd", 32'h0000_0010, 8'h3C);
        chk("stop_sticky", program_stop, 1'b1);

        // Reset during a pending read
        cpu_mem_a  = 32'h0000_0010;
        cpu_mem_wr = 1'b0;
        rst_in     = 1'b1;
        tick();
        chk("mid_rst_din", cpu_mem_din, 8'h00);
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_rx_ready", rx_ready, 1'b1);
        chk("mid_rst_buf_full", io_buffer_full, 1'b0);
        chk("mid_rst_stop", program_stop, 1'b0);
        chk("mid_rst_ovf", tx_overflow, 1'b0);
        rst_in = 1'b0;
        idle();
        tick();
        bus_rd("post_rst_cnt", 32'h0003_0004, m_cnt[7:0]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
